// File: rtl/chess_pkg.sv
// rtl/chess_pkg.sv - piece codes, cell/state types and board helpers for move_controller
package chess_pkg;

  typedef enum logic [2:0] {
    EMPTY  = 3'd0,
    PAWN   = 3'd1,
    BISHOP = 3'd2,
    KNIGHT = 3'd3,
    ROOK   = 3'd4,
    QUEEN  = 3'd5,
    KING   = 3'd6
  } piece_t;

  localparam logic WHITE = 1'b0;
  localparam logic BLACK = 1'b1;

  typedef struct packed {
    logic   colour;
    piece_t kind;
  } cell_t;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_PICKED, S_COMMIT} state_t;

  function automatic logic [5:0] sq_idx(input logic [2:0] x, input logic [2:0] y);
    return {y, x};
  endfunction

  // Start position: black on rows 0-1, white on rows 6-7.
  function automatic cell_t start_cell(input logic [5:0] idx);
    piece_t back;
    cell_t  c;
    case (idx[2:0])
      3'd0, 3'd7: back = ROOK;
      3'd1, 3'd6: back = KNIGHT;
      3'd2, 3'd5: back = BISHOP;
      3'd3:       back = QUEEN;
      default:    back = KING;
    endcase
    case (idx[5:3])
      3'd0:    c = '{BLACK, back};
      3'd1:    c = '{BLACK, PAWN};
      3'd6:    c = '{WHITE, PAWN};
      3'd7:    c = '{WHITE, back};
      default: c = '{WHITE, EMPTY};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cursor_nav.sv
// rtl/cursor_nav.sv - button priority, wrap-around cursor registers and blink divider
module cursor_nav #(
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic       clk_6p25,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_centre,
  output logic [2:0] cursor_x,
  output logic [2:0] cursor_y,
  output logic       cursor_blink,
  output logic       centre
);

  localparam int CW = $clog2(BLINK_DIV);

  logic [CW-1:0] blink_cnt;

  assign centre = enable & btn_centre;

  always_ff @(posedge clk_6p25) begin
    if (!rst_n) begin
      cursor_x     <= 3'd4;
      cursor_y     <= 3'd6;
      cursor_blink <= 1'b0;
      blink_cnt    <= '0;
    end else begin
      // Centre outranks every direction, so a centre press freezes the cursor.
      if (enable && !btn_centre) begin
        if (btn_up)         cursor_y <= cursor_y - 3'd1;
        else if (btn_down)  cursor_y <= cursor_y + 3'd1;
        else if (btn_left)  cursor_x <= cursor_x - 3'd1;
        else if (btn_right) cursor_x <= cursor_x + 3'd1;
      end
      if (blink_cnt == CW'(BLINK_DIV - 1)) begin
        blink_cnt    <= '0;
        cursor_blink <= ~cursor_blink;
      end else begin
        blink_cnt <= blink_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/move_controller.sv
// rtl/move_controller.sv - board owner and select/query/commit FSM; PROMOTION_EN enables pawn promotion
module move_controller
  import chess_pkg::*;
#(
  parameter int REQ_TIMEOUT = 1023,
  parameter int BLINK_DIV   = 25_000_000
) (
  input  logic        clk_6p25,
  input  logic        rst_n,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_centre,
  input  logic        avail_valid,
  input  logic [63:0] avail_mask,
  input  logic [5:0]  cell_rd_idx,
  output logic        sel_req,
  output logic [2:0]  sel_x,
  output logic [2:0]  sel_y,
  output logic [2:0]  cursor_x,
  output logic [2:0]  cursor_y,
  output logic        cursor_blink,
  output logic [63:0] avail_array,
  output logic [2:0]  old_x,
  output logic [2:0]  old_y,
  output logic [2:0]  new_x,
  output logic [2:0]  new_y,
  output logic [2:0]  piece,
  output logic        colour,
  output logic        move_valid,
  output logic        turn,
  output logic [3:0]  cell_rd_data
);

  localparam int TW = $clog2(REQ_TIMEOUT + 1);

  cell_t         board [64];
  state_t        state;
  logic [TW-1:0] req_timer;
  logic          centre;
  cell_t         cur_cell;
  cell_t         src_cell;
  piece_t        moved_kind;

  cursor_nav #(.BLINK_DIV(BLINK_DIV)) u_nav (
    .clk_6p25     (clk_6p25),
    .rst_n        (rst_n),
    .enable       (state == S_IDLE || state == S_PICKED),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .btn_centre   (btn_centre),
    .cursor_x     (cursor_x),
    .cursor_y     (cursor_y),
    .cursor_blink (cursor_blink),
    .centre       (centre)
  );

  assign cur_cell     = board[sq_idx(cursor_x, cursor_y)];
  assign src_cell     = board[sq_idx(sel_x, sel_y)];
  assign cell_rd_data = board[cell_rd_idx];

  always_comb begin
    moved_kind = src_cell.kind;
`ifdef PROMOTION_EN
    if (src_cell.kind == PAWN &&
        ((src_cell.colour == WHITE && cursor_y == 3'd0) ||
         (src_cell.colour == BLACK && cursor_y == 3'd7)))
      moved_kind = QUEEN;
`endif
  end

  // Move outputs and turn update when leaving PICKED; the board write lands one cycle later.
  always_ff @(posedge clk_6p25) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) board[i] <= start_cell(6'(i));
      state       <= S_IDLE;
      req_timer   <= '0;
      sel_req     <= 1'b0;
      sel_x       <= '0;
      sel_y       <= '0;
      avail_array <= '0;
      old_x       <= '0;
      old_y       <= '0;
      new_x       <= '0;
      new_y       <= '0;
      piece       <= '0;
      colour      <= 1'b0;
      move_valid  <= 1'b0;
      turn        <= 1'b0;
    end else begin
      sel_req    <= 1'b0;
      move_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (centre && cur_cell.kind != EMPTY && cur_cell.colour == turn) begin
            sel_x     <= cursor_x;
            sel_y     <= cursor_y;
            sel_req   <= 1'b1;
            req_timer <= '0;
            state     <= S_REQ;
          end
        end
        S_REQ: begin
          if (avail_valid) begin
            if (avail_mask != '0) begin
              avail_array <= avail_mask;
              state       <= S_PICKED;
            end else begin
              state <= S_IDLE;
            end
          end else if (req_timer == TW'(REQ_TIMEOUT - 1)) begin
            state <= S_IDLE;
          end else begin
            req_timer <= req_timer + TW'(1);
          end
        end
        S_PICKED: begin
          if (centre) begin
            if (cursor_x == sel_x && cursor_y == sel_y) begin
              avail_array <= '0;
              state       <= S_IDLE;
            end else if (avail_array[sq_idx(cursor_x, cursor_y)]) begin
              old_x       <= sel_x;
              old_y       <= sel_y;
              new_x       <= cursor_x;
              new_y       <= cursor_y;
              piece       <= moved_kind;
              colour      <= src_cell.colour;
              move_valid  <= 1'b1;
              turn        <= ~turn;
              avail_array <= '0;
              state       <= S_COMMIT;
            end
          end
        end
        S_COMMIT: begin
          board[sq_idx(new_x, new_y)] <= '{colour, piece_t'(piece)};
          board[sq_idx(old_x, old_y)] <= '{WHITE, EMPTY};
          state                       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_move_controller.sv
// tb/tb_move_controller.sv - directed bench with a game-level model checked every cycle
module tb_move_controller;

  localparam int T_OUT = 1023;
  localparam int BLINK = 5;
`ifdef PROMOTION_EN
  localparam bit PROMO = 1'b1;
`else
  localparam bit PROMO = 1'b0;
`endif
  localparam logic [4:0] C = 5'b10000, U = 5'b01000, D = 5'b00100, L = 5'b00010, R = 5'b00001;
  localparam logic [4:0] NONE = 5'b00000;

  logic        clk_6p25 = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_up = 0, btn_down = 0, btn_left = 0, btn_right = 0, btn_centre = 0;
  logic        avail_valid = 0;
  logic [63:0] avail_mask = '0;
  logic [5:0]  cell_rd_idx = '0;
  logic        sel_req, cursor_blink, colour, move_valid, turn;
  logic [2:0]  sel_x, sel_y, cursor_x, cursor_y, old_x, old_y, new_x, new_y, piece;
  logic [63:0] avail_array;
  logic [3:0]  cell_rd_data;

  move_controller #(.REQ_TIMEOUT(T_OUT), .BLINK_DIV(BLINK)) dut (
    .clk_6p25(clk_6p25), .rst_n(rst_n),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .btn_centre(btn_centre), .avail_valid(avail_valid), .avail_mask(avail_mask),
    .cell_rd_idx(cell_rd_idx), .sel_req(sel_req), .sel_x(sel_x), .sel_y(sel_y),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .cursor_blink(cursor_blink),
    .avail_array(avail_array), .old_x(old_x), .old_y(old_y), .new_x(new_x), .new_y(new_y),
    .piece(piece), .colour(colour), .move_valid(move_valid), .turn(turn),
    .cell_rd_data(cell_rd_data)
  );

  always #5 clk_6p25 = ~clk_6p25;

  int n_checks = 0;
  int n_errors = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Game-level model: board as 64 squares, phase 0 idle, 1 waiting, 2 picked, 3 writing.
  int          m_kind [64];
  int          m_col  [64];
  int          m_cx, m_cy, m_sx, m_sy, m_ox, m_oy, m_nx, m_ny, m_piece, m_colour;
  int          m_turn, m_blink, m_bcnt, m_phase, m_wait;
  bit          m_sel_req, m_mv;
  logic [63:0] m_avail;
  bit          active;
  int          here, src, pk;

  function automatic int code_of(byte ch);
    case (ch)
      "R": return 4;
      "N": return 3;
      "B": return 2;
      "Q": return 5;
      default: return 6;
    endcase
  endfunction

  task automatic model_reset();
    string back = "RNBQKBNR";
    for (int i = 0; i < 64; i++) begin
      m_kind[i] = 0;
      m_col[i]  = 0;
    end
    for (int x = 0; x < 8; x++) begin
      m_kind[x]      = code_of(back[x]);  m_col[x]      = 1;
      m_kind[8 + x]  = 1;                 m_col[8 + x]  = 1;
      m_kind[48 + x] = 1;                 m_col[48 + x] = 0;
      m_kind[56 + x] = code_of(back[x]);  m_col[56 + x] = 0;
    end
    m_cx = 4; m_cy = 6; m_sx = 0; m_sy = 0; m_ox = 0; m_oy = 0; m_nx = 0; m_ny = 0;
    m_piece = 0; m_colour = 0; m_turn = 0; m_blink = 0; m_bcnt = 0; m_phase = 0;
    m_wait = 0; m_sel_req = 0; m_mv = 0; m_avail = '0;
  endtask

  always @(posedge clk_6p25) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      active    = (m_phase == 0 || m_phase == 2);
      here      = m_cy * 8 + m_cx;
      src       = m_sy * 8 + m_sx;
      m_sel_req = 0;
      m_mv      = 0;
      m_bcnt++;
      if (m_bcnt == BLINK) begin
        m_bcnt  = 0;
        m_blink = 1 - m_blink;
      end
      case (m_phase)
        0: if (btn_centre && m_kind[here] != 0 && m_col[here] == m_turn) begin
          m_sx = m_cx; m_sy = m_cy; m_sel_req = 1; m_wait = 0; m_phase = 1;
        end
        1: if (avail_valid) begin
          if (avail_mask != 0) begin
            m_avail = avail_mask;
            m_phase = 2;
          end else m_phase = 0;
        end else begin
          m_wait++;
          if (m_wait == T_OUT) m_phase = 0;
        end
        2: if (btn_centre) begin
          if (here == src) begin
            m_avail = '0;
            m_phase = 0;
          end else if (m_avail[here]) begin
            pk = m_kind[src];
            if (PROMO && pk == 1 && ((m_col[src] == 0 && m_cy == 0) || (m_col[src] == 1 && m_cy == 7)))
              pk = 5;
            m_ox = m_sx; m_oy = m_sy; m_nx = m_cx; m_ny = m_cy;
            m_piece = pk; m_colour = m_col[src]; m_mv = 1; m_turn = 1 - m_turn;
            m_avail = '0; m_phase = 3;
          end
        end
        default: begin
          m_kind[m_ny * 8 + m_nx] = m_piece;
          m_col[m_ny * 8 + m_nx]  = m_colour;
          m_kind[m_oy * 8 + m_ox] = 0;
          m_col[m_oy * 8 + m_ox]  = 0;
          m_phase = 0;
        end
      endcase
      if (active && !btn_centre) begin
        if (btn_up)         m_cy = (m_cy + 7) % 8;
        else if (btn_down)  m_cy = (m_cy + 1) % 8;
        else if (btn_left)  m_cx = (m_cx + 7) % 8;
        else if (btn_right) m_cx = (m_cx + 1) % 8;
      end
    end
  end

  bit chk_on = 0;

  always @(negedge clk_6p25) begin
    if (chk_on) begin
      chk("cursor", {cursor_x, cursor_y}, {3'(m_cx), 3'(m_cy)});
      chk("blink", cursor_blink, m_blink[0]);
      chk("turn", turn, m_turn[0]);
      chk("sel_req", sel_req, m_sel_req);
      chk("sel", {sel_x, sel_y}, {3'(m_sx), 3'(m_sy)});
      chk("avail_array", avail_array, m_avail);
      chk("move_valid", move_valid, m_mv);
      chk("last_move", {old_x, old_y, new_x, new_y, piece, colour},
          {3'(m_ox), 3'(m_oy), 3'(m_nx), 3'(m_ny), 3'(m_piece), m_colour[0]});
      #2;
      chk("cell_rd", cell_rd_data, {m_col[cell_rd_idx][0], 3'(m_kind[cell_rd_idx])});
    end
  end

  logic [5:0] scan = '0;

  task automatic step(input logic [4:0] b);
    @(negedge clk_6p25);
    {btn_centre, btn_up, btn_down, btn_left, btn_right} = b;
    avail_valid = 1'b0;
    avail_mask  = '0;
    cell_rd_idx = scan;
    scan        = scan + 6'd1;
  endtask

  task automatic answer(input logic [63:0] m);
    step(NONE);
    avail_valid = 1'b1;
    avail_mask  = m;
  endtask

  task automatic moves(input logic [4:0] b, input int n);
    repeat (n) step(b);
    step(NONE);
  endtask

  task automatic rd(input string nm, input int idx, input logic [3:0] exp);
    cell_rd_idx = 6'(idx);
    #1;
    chk(nm, cell_rd_data, exp);
  endtask

  initial begin
    // Reset and start position
    repeat (3) step(NONE);
    chk_on = 1;
    rst_n  = 1'b1;
    step(NONE);
    chk("rst_cursor", {cursor_x, cursor_y}, {3'd4, 3'd6});
    chk("rst_turn", turn, 1'b0);
    chk("rst_outputs", {sel_req, move_valid, avail_array, piece, colour}, '0);
    rd("start_a8_rook", 0, 4'hC);
    rd("start_black_queen", 3, 4'hD);
    rd("start_black_king", 4, 4'hE);
    rd("start_black_pawn", 9, 4'h9);
    rd("start_empty", 26, 4'h0);
    rd("start_white_pawn", 52, 4'h1);
    rd("start_white_knight", 57, 4'h3);
    rd("start_white_bishop", 58, 4'h2);
    rd("start_white_queen", 59, 4'h5);
    rd("start_white_king", 60, 4'h6);
    repeat (64) step(NONE);

    // Wrap-around and priority
    moves(L, 4);
    moves(U, 6);
    chk("at_origin", {cursor_x, cursor_y}, {3'd0, 3'd0});
    moves(L, 1);
    chk("wrap_left", {cursor_x, cursor_y}, {3'd7, 3'd0});
    moves(U, 1);
    chk("wrap_up", {cursor_x, cursor_y}, {3'd7, 3'd7});
    step(C | R);
    step(NONE);
    chk("centre_wins", {cursor_x, cursor_y, sel_req}, {3'd7, 3'd7, 1'b1});
    moves(L, 1);
    chk("req_ignores_cursor", {cursor_x, cursor_y}, {3'd7, 3'd7});
    answer(64'h0);
    step(NONE);
    moves(L, 1);
    chk("empty_mask_idle", {cursor_x, cursor_y, avail_array}, {3'd6, 3'd7, 64'h0});

    // Wrong side and empty square are ignored
    moves(L, 6);
    moves(U, 6);
    step(C);
    step(NONE);
    chk("wrong_side_no_req", sel_req, 1'b0);
    moves(U | D | L | R, 1);
    chk("prio_up", {cursor_x, cursor_y}, {3'd0, 3'd0});
    moves(D | L | R, 1);
    chk("prio_down", {cursor_x, cursor_y}, {3'd0, 3'd1});
    moves(L | R, 1);
    chk("prio_left", {cursor_x, cursor_y}, {3'd7, 3'd1});
    moves(R, 1);
    moves(D, 2);
    step(C);
    step(NONE);
    chk("empty_no_req", sel_req, 1'b0);

    // White e-pawn two squares forward
    moves(R, 4);
    moves(D, 3);
    step(C);
    step(NONE);
    chk("e2_sel_req", {sel_req, sel_x, sel_y}, {1'b1, 3'd4, 3'd6});
    answer((64'd1 << 36) | (64'd1 << 44));
    step(NONE);
    chk("e2_mask", avail_array, 64'h0000_1010_0000_0000);
    moves(U, 2);
    step(C);
    step(NONE);
    chk("e2_commit", {move_valid, old_x, old_y, new_x, new_y, piece, colour, turn},
        {1'b1, 3'd4, 3'd6, 3'd4, 3'd4, 3'd1, 1'b0, 1'b1});
    step(NONE);
    chk("e2_pulse_end", move_valid, 1'b0);
    rd("e2_src_empty", 52, 4'h0);
    rd("e2_dst_pawn", 36, 4'h1);

    // Timeout: answer one cycle too late is ignored
    moves(L, 1);
    moves(U, 3);
    step(C);
    step(NONE);
    chk("to_sel_req", sel_req, 1'b1);
    repeat (T_OUT - 1) step(NONE);
    answer(64'd1 << 19);
    step(NONE);
    chk("late_answer_ignored", avail_array, 64'h0);
    // Answer on the last waiting cycle is accepted
    step(C);
    step(NONE);
    chk("reissue_sel_req", sel_req, 1'b1);
    repeat (T_OUT - 2) step(NONE);
    answer((64'd1 << 19) | (64'd1 << 27));
    step(NONE);
    chk("last_cycle_answer", avail_array, 64'h0000_0000_0808_0000);
    moves(R, 1);
    step(C);
    step(NONE);
    chk("non_mask_ignored", {avail_array, move_valid}, {64'h0000_0000_0808_0000, 1'b0});
    moves(L, 1);
    step(C);
    step(NONE);
    chk("cancel", {avail_array, turn}, {64'h0, 1'b1});
    rd("cancel_board", 11, 4'h9);

    // Black h-pawn, then white pawn captures onto row 0
    moves(R, 4);
    step(C);
    step(NONE);
    answer(64'd1 << 31);
    moves(D, 2);
    step(C);
    step(NONE);
    chk("black_commit", {move_valid, colour, turn}, {1'b1, 1'b1, 1'b0});
    step(NONE);
    rd("h_pawn", 31, 4'h9);
    moves(L, 3);
    moves(D, 1);
    step(C);
    step(NONE);
    answer(64'd1 << 3);
    moves(U, 4);
    moves(L, 1);
    step(C);
    step(NONE);
    chk("promo_piece", {piece, colour}, {PROMO ? 3'd5 : 3'd1, 1'b0});
    step(NONE);
    rd("promo_cell", 3, PROMO ? 4'h5 : 4'h1);

    // Reset while a selection is picked
    moves(D, 1);
    step(C);
    step(NONE);
    answer(64'd1 << 27);
    step(NONE);
    rst_n = 1'b0;
    step(NONE);
    step(NONE);
    rst_n = 1'b1;
    step(NONE);
    chk("midreset_state", {cursor_x, cursor_y, turn, avail_array}, {3'd4, 3'd6, 1'b0, 64'h0});
    rd("midreset_board", 3, 4'hD);
    rd("midreset_e2", 52, 4'h1);
    repeat (70) step(NONE);

    chk_on = 0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
